// File: rtl/matmul_mem_engine.sv
// ---------------------------------------------------------------------------
// matmul_mem_engine
//   NxN signed matrix-multiply engine with its own memory-fetch FSM.
//   Fetches A then B over a req/ack word bus, computes C = A*B (mode 0) or
//   C = A*B^T (mode 1) with one MAC per cycle, writes C back, pulses done.
//
//   Optional build macro: MATMUL_SATURATE_EN
//     defined   -> each C element is clamped to the signed W-bit range
//     undefined -> the low W bits of the accumulator are stored (wrap)
//   Either way the stored W-bit element is sign-extended to DW on the bus.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               begin an operation (sampled only in IDLE)
//   mode                0: A*B, 1: A*B^T (latched at start)
//   base_a/b/c          byte base addresses (latched at start)
//   busy                high from the cycle after start until done
//   done                one-cycle pulse when the C store completes
//   mem_req/we/addr/wdata  memory request, held until acked
//   mem_ack, mem_rdata  memory accept (rdata valid in the same cycle)
//   dbg_state           current FSM state, for observation only
//
// Handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held
// unchanged until a cycle with mem_ack=1; that cycle completes the transfer
// and the next request, if any, is presented in the following cycle.
// mem_ack while mem_req is low has no effect.
// ---------------------------------------------------------------------------
module matmul_mem_engine #(
    parameter int N  = 3,
    parameter int W  = 16,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    dbg_state
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CW    = $clog2(N);
    localparam int ACC_W = 2 * W + $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_STORE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state;
    logic                mode_q;
    logic [AW-1:0]       base_a_q;
    logic [AW-1:0]       base_b_q;
    logic [AW-1:0]       base_c_q;
    logic                ld_b;      // 0: fetching A, 1: fetching B
    logic [IDX_W-1:0]    idx;       // element index for load/store
    logic [CW-1:0]       ci;
    logic [CW-1:0]       cj;
    logic [CW-1:0]       ck;
    logic signed [ACC_W-1:0] acc;

    logic signed [W-1:0] a_mem [NN];
    logic signed [W-1:0] b_mem [NN];
    logic signed [W-1:0] c_mem [NN];

    logic [IDX_W-1:0]        nidx;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        b_idx;
    logic [IDX_W-1:0]        c_idx;
    logic                    idx_last;
    logic                    k_last;
    logic                    j_last;
    logic                    i_last;
    logic signed [W-1:0]     a_op;
    logic signed [W-1:0]     b_op;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [W-1:0]     c_res;
    logic                    xfer;
    logic                    rdata_unused;

    assign dbg_state    = state;
    assign xfer         = mem_req && mem_ack;
    // Only the low W bits of a read word carry an element.
    assign rdata_unused = ^mem_rdata;

`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

    function automatic logic [DW-1:0] sext(input logic signed [W-1:0] v);
        return DW'(v);
    endfunction

    function automatic logic [AW-1:0] word_off(input logic [IDX_W-1:0] i);
        return AW'(i) << 2;
    endfunction

    always_comb begin
        nidx     = idx + IDX_W'(1);
        idx_last = (idx == IDX_W'(NN - 1));
        k_last   = (ck == CW'(N - 1));
        j_last   = (cj == CW'(N - 1));
        i_last   = (ci == CW'(N - 1));
        a_idx    = IDX_W'(ci) * IDX_W'(N) + IDX_W'(ck);
        // mode 1 reads B transposed: B[j][k] instead of B[k][j]
        b_idx    = mode_q ? (IDX_W'(cj) * IDX_W'(N) + IDX_W'(ck))
                          : (IDX_W'(ck) * IDX_W'(N) + IDX_W'(cj));
        c_idx    = IDX_W'(ci) * IDX_W'(N) + IDX_W'(cj);
        a_op     = a_mem[a_idx];
        b_op     = b_mem[b_idx];
        prod     = ACC_W'(a_op) * ACC_W'(b_op);
        // Accumulator restarts at k=0 so no separate clear cycle is needed.
        acc_next = (ck == '0) ? prod : (acc + prod);
`ifdef MATMUL_SATURATE_EN
        if (acc_next > SAT_MAX) begin
            c_res = SAT_MAX[W-1:0];
        end else if (acc_next < SAT_MIN) begin
            c_res = SAT_MIN[W-1:0];
        end else begin
            c_res = acc_next[W-1:0];
        end
`else
        c_res = acc_next[W-1:0];
`endif
    end

    // Matrix storage has no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && xfer) begin
            if (ld_b) begin
                b_mem[idx] <= mem_rdata[W-1:0];
            end else begin
                a_mem[idx] <= mem_rdata[W-1:0];
            end
        end
        if (!rst && state == S_COMPUTE && k_last) begin
            c_mem[c_idx] <= c_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mode_q    <= 1'b0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            ld_b      <= 1'b0;
            idx       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        base_c_q <= base_c;
                        busy     <= 1'b1;
                        ld_b     <= 1'b0;
                        idx      <= '0;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (!mem_req) begin
                        // First read goes out one cycle after the bases latch.
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= base_a_q;
                    end else if (mem_ack) begin
                        if (idx_last) begin
                            idx <= '0;
                            if (ld_b) begin
                                mem_req <= 1'b0;
                                ci      <= '0;
                                cj      <= '0;
                                ck      <= '0;
                                state   <= S_COMPUTE;
                            end else begin
                                ld_b     <= 1'b1;
                                mem_addr <= base_b_q;
                            end
                        end else begin
                            idx      <= nidx;
                            mem_addr <= (ld_b ? base_b_q : base_a_q) + word_off(nidx);
                        end
                    end
                end

                S_COMPUTE: begin
                    acc <= acc_next;
                    if (k_last) begin
                        ck <= '0;
                        if (j_last) begin
                            cj <= '0;
                            if (i_last) begin
                                // C[0][0] was finished long ago, so the
                                // first write can go out immediately.
                                ci        <= '0;
                                idx       <= '0;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= base_c_q;
                                mem_wdata <= sext(c_mem[0]);
                                state     <= S_STORE;
                            end else begin
                                ci <= ci + CW'(1);
                            end
                        end else begin
                            cj <= cj + CW'(1);
                        end
                    end else begin
                        ck <= ck + CW'(1);
                    end
                end

                S_STORE: begin
                    if (mem_ack) begin
                        if (idx_last) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            idx     <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            idx       <= nidx;
                            mem_addr  <= base_c_q + word_off(nidx);
                            mem_wdata <= sext(c_mem[nidx]);
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_mem_engine.sv
module tb_matmul_mem_engine;

    localparam int N       = 3;
    localparam int W       = 16;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NN      = N * N;
    localparam int EXP_LAT = 3 * NN + N * N * N + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [AW-1:0] base_c;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    matmul_mem_engine #(.N(N), .W(W), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wa_q[$];
    logic [DW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int ea [NN];
    int eb [NN];

    function automatic logic [DW-1:0] ref_c(input int i, input int j, input bit m);
        longint s;
        logic signed [W-1:0] t;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += longint'(ea[i*N+k]) * longint'(m ? eb[j*N+k] : eb[k*N+j]);
        end
`ifdef MATMUL_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        t = s[W-1:0];
        return {{(DW-W){t[W-1]}}, t};
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0]   mem [0:1023];
    bit            tied_ack = 1'b1;
    bit            delay_en = 1'b0;
    int            wait_cnt = 0;
    bit            pending  = 1'b0;
    logic [AW-1:0] hold_addr;
    logic          hold_we;
    logic [DW-1:0] hold_wdata;
    int            rd_cnt = 0;
    int            wr_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack  = 1'b0;
            pending  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req) begin
            if (pending) begin
                check("hold_addr", mem_addr, hold_addr);
                check("hold_we", mem_we, hold_we);
                if (hold_we) check("hold_wdata", mem_wdata, hold_wdata);
            end
            if (tied_ack || wait_cnt == 0) begin
                mem_ack = 1'b1;
                pending = 1'b0;
                if (mem_we) begin
                    wr_cnt++;
                    mem[mem_addr[11:2]] = mem_wdata;
                    if (exp_q.size() > 0) begin
                        check("wr_addr", mem_addr, exp_wa_q.pop_front());
                        check("wr_data", mem_wdata, exp_q.pop_front());
                    end else begin
                        check("extra_write", wr_cnt, NN);
                    end
                end else begin
                    rd_cnt++;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (exp_rd_q.size() > 0) begin
                        check("rd_addr", mem_addr, exp_rd_q.pop_front());
                    end else begin
                        check("extra_read", rd_cnt, 2 * NN);
                    end
                end
                wait_cnt = delay_en ? int'($urandom_range(0, 3)) : 0;
            end else begin
                mem_ack    = 1'b0;
                mem_rdata  = $urandom;
                wait_cnt--;
                pending    = 1'b1;
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end
        end else begin
            // An ack with no request must be ignored by the engine.
            mem_ack = tied_ack ? 1'b1 : 1'($urandom_range(0, 1));
            pending = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_mats(input int kind);
        logic [15:0] r;
        for (int i = 0; i < NN; i++) begin
            case (kind)
                0: begin ea[i] = (i / N == i % N) ? 1 : 0; eb[i] = i + 1; end
                1: begin ea[i] = -2; eb[i] = -2; end
                2: begin ea[i] = 32767; eb[i] = 32767; end
                3: begin
                    r = 16'($urandom); ea[i] = int'($signed(r));
                    r = 16'($urandom); eb[i] = int'($signed(r));
                end
                default: begin
                    ea[i] = int'($urandom_range(0, 15)) - 8;
                    eb[i] = int'($urandom_range(0, 15)) - 8;
                end
            endcase
        end
    endtask

    task automatic prep_op(input bit m, input bit tie, input bit dly);
        int wa;
        int wb;
        int wc;
        tied_ack = tie;
        delay_en = dly;
        mode     = m;
        base_a   = 32'(4 * $urandom_range(0, 40));
        base_b   = 32'h400 + 32'(4 * $urandom_range(0, 40));
        base_c   = 32'h800 + 32'(4 * $urandom_range(0, 40));
        wa = int'(base_a >> 2);
        wb = int'(base_b >> 2);
        wc = int'(base_c >> 2);
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_q.delete();
        for (int i = 0; i < NN; i++) begin
            mem[wa+i] = {16'($urandom), ea[i][15:0]};
            mem[wb+i] = {16'($urandom), eb[i][15:0]};
            mem[wc+i] = $urandom;
            exp_rd_q.push_back(base_a + 32'(4 * i));
        end
        for (int i = 0; i < NN; i++) exp_rd_q.push_back(base_b + 32'(4 * i));
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_wa_q.push_back(base_c + 32'(4 * (i * N + j)));
                exp_q.push_back(ref_c(i, j, m));
            end
        end
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    // Called at a falling edge with the engine idle; returns in IDLE.
    task automatic run_op(input bit m, input bit tie, input bit dly, input bit chk_lat,
                          input string name);
        int cyc;
        bit seen;
        prep_op(m, tie, dly);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        check({name, "_busy"}, busy, 1'b1);
        seen = 1'b0;
        while (cyc < 2000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            // Stray starts while busy must be ignored.
            start = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, seen, 1'b1);
        if (chk_lat) check({name, "_latency"}, cyc, EXP_LAT);
        check({name, "_reads"}, rd_cnt, 2 * NN);
        check({name, "_writes"}, wr_cnt, NN);
        check({name, "_wr_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 1'b0);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_req"}, mem_req, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        base_a = '0;
        base_b = '0;
        base_c = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        rst = 1'b0;
        @(negedge clk);

        set_mats(0); run_op(1'b0, 1'b1, 1'b0, 1'b1, "t1_ident_m0");
        run_op(1'b1, 1'b1, 1'b0, 1'b1, "t2_ident_m1");
        set_mats(1); run_op(1'b0, 1'b1, 1'b0, 1'b1, "t3_neg2");
        set_mats(2); run_op(1'b0, 1'b1, 1'b0, 1'b1, "t4_max");
        set_mats(0); run_op(1'b0, 1'b0, 1'b1, 1'b0, "t5_delay");

        // Abort after the 5th load ack, then a fresh run must succeed.
        set_mats(3);
        prep_op(1'b0, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #1;
            if (rd_cnt >= 5) break;
        end
        check("t6_hit5", rd_cnt, 5);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_req", mem_req, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        rst = 1'b0;
        set_mats(3); run_op(1'b1, 1'b1, 1'b0, 1'b1, "t6_after_rst");

        for (int r = 0; r < 6; r++) begin
            bit tie;
            tie = 1'($urandom_range(0, 1));
            set_mats((r % 2 == 0) ? 3 : 4);
            run_op(1'($urandom_range(0, 1)), tie, !tie, tie, "t7_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
